mem_refill_responder: RTL and testbench
=======================================

# mem_refill_responder

Memory-side responder for cache miss traffic in the pipelined MIPS core. Accepts one line-refill or single-word write request at a time from the cache controllers (the initiator side that raises dmiss), models fixed main-memory latency, then returns the line as a burst of word beats. While a request is outstanding, `busy` drives the pipeline's miss stall.

## Interface
Parameters:
- `LINE_WORDS`, 4: words per cache line; power of 2, ≥2.
- `LATENCY`, 5: cycles from request acceptance to first response beat; ≥1.
- `MEM_BYTES`, 1024: size of backing byte array `bytes[0:MEM_BYTES-1]`; power of 2.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder idle, request accepted this cycle if `req_valid`.
- `req_we`  in  1  1 = single-word write, 0 = line refill.
- `req_addr`  in  32  byte address; bits [1:0] ignored.
- `req_wdata`  in  32  write data, used when `req_we`=1.
- `resp_valid`  out  1  response beat valid this cycle.
- `resp_data`  out  32  beat data; 0 on write acks.
- `resp_beat`  out  log2(LINE_WORDS)  word index within line of this beat.
- `resp_last`  out  1  final beat of the transaction.
- `busy`  out  1  request outstanding; feeds miss stall.

## Operation
- States: IDLE, WAIT, BURST.
- IDLE: `req_ready`=1. On `req_valid`, capture addr/we/wdata, load latency counter with LATENCY-1, go WAIT.
- WAIT: counter decrements each cycle; at 0 go BURST (refill) or emit a one-cycle ack (write: `resp_valid`=1, `resp_last`=1, `resp_data`=0, `resp_beat`=addr word index) and return to IDLE.
- Write commits to `bytes` on the edge the ack is emitted.
- BURST: one beat per cycle, no backpressure; LINE_WORDS beats; last beat sets `resp_last`, then IDLE.
- Word fetch is big-endian: word at byte address A = {bytes[A], bytes[A+1], bytes[A+2], bytes[A+3]}; writes store the same order.
- Addresses wrap modulo MEM_BYTES; line base = addr with low log2(LINE_WORDS)+2 bits cleared.
- Beat index arithmetic is modulo LINE_WORDS (wraps within the line, never crosses into the next line).
- `req_valid` in WAIT/BURST is ignored (`req_ready`=0); initiator must hold it.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_beat`=0, `resp_last`=0, `busy`=0. `bytes` not cleared.
- Request accepted at edge T → `busy`=1 from T; first `resp_valid` in cycle after edge T+LATENCY.
- Refill occupies LATENCY+LINE_WORDS cycles; `busy` falls and `req_ready` rises in cycle after last beat, so a back-to-back request is accepted at the earliest one cycle after `resp_last`.
- Write: ack in cycle after edge T+LATENCY; readback of written word visible to any later request.
- `busy` = state ≠ IDLE; `req_ready` = state == IDLE (purely state-derived, no combinational path from `req_valid`).
- Reset asserted mid-WAIT/BURST: immediate abort, outputs to reset values, no further beats; an uncommitted write is dropped.

## Configuration
- `REFILL_CWF_EN` defined: critical-word-first — first beat is the requested word index, subsequent beats increment and wrap modulo LINE_WORDS (request word 2 of 4 → beats 2,3,0,1).
- Not defined: beats always 0,1,…,LINE_WORDS-1 regardless of requested word.

## Test plan
- Preload bytes[0..7]=F0,78,3C,1E,0F,07,03,00; refill addr 0x0, LATENCY=5 → first beat 5 cycles after accept, beat0=0xF0783C1E, beat1=0x0F070300, beats 2,3=0, `resp_last` on beat 3, `busy` low next cycle.
- With `REFILL_CWF_EN`, refill addr 0x4 → `resp_beat` sequence 1,2,3,0, first data 0x0F070300; without macro → 0,1,2,3.
- Write addr 0x10 data 0xDEADBEEF, then refill 0x10 → ack with `resp_last`=1, `resp_data`=0; refill beat0=0xDEADBEEF, bytes[16]=0xDE.
- Hold `req_valid` during a burst with a second request → not accepted until cycle after `resp_last`; second response starts LATENCY cycles after that acceptance.
- Assert `reset` low during beat 1 of a refill → `resp_valid`/`busy` 0 immediately, `req_ready`=1; new request after release completes normally.
- Refill addr MEM_BYTES+0x4 → identical data to addr 0x4 (modulo wrap).

Source files
------------

// File: rtl/mem_refill_responder.sv
// mem_refill_responder
//   Memory-side responder for cache miss traffic. It accepts one line refill
//   or one single-word write at a time, waits a fixed memory latency, and then
//   returns either a burst of LINE_WORDS word beats (refill) or a one-beat
//   acknowledge (write). The `busy` output drives the pipeline miss stall.
//
// Parameters
//   LINE_WORDS  words per cache line (power of 2, >= 2)
//   LATENCY     cycles from acceptance to the first response beat (>= 1)
//   MEM_BYTES   size of the backing byte array (power of 2, > 4*LINE_WORDS)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   req_valid   request present; the initiator holds it until accepted
//   req_ready   responder idle; a request is taken this cycle if req_valid
//   req_we      1 = single-word write, 0 = line refill
//   req_addr    byte address; bits [1:0] ignored, wraps modulo MEM_BYTES
//   req_wdata   write data, used when req_we = 1
//   resp_valid  response beat valid
//   resp_data   beat data, big-endian word; 0 on write acknowledges
//   resp_beat   word index within the line for this beat
//   resp_last   final beat of the transaction
//   busy        request outstanding
//
// Build option
//   REFILL_CWF_EN  critical-word-first: the burst starts at the requested
//                  word and wraps within the line. Undefined: bursts always
//                  start at word 0.

module mem_refill_responder #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned MEM_BYTES  = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          resp_valid,
  output logic [31:0]                   resp_data,
  output logic [$clog2(LINE_WORDS)-1:0] resp_beat,
  output logic                          resp_last,
  output logic                          busy
);

  localparam int unsigned BW = $clog2(LINE_WORDS);
  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned WW = AW - 2;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [WW-1:0] LINE_MASK = WW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] LAT_LOAD  = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [BW-1:0] nbeat_q, nbeat_d;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [WW-1:0] waddr_q;

  logic          accept;
  logic          mem_we;
  logic [BW-1:0] first_beat;
  logic [WW-1:0] rd_waddr;

  logic [7:0]    bytes [0:MEM_BYTES-1];

  // Address bits outside the wrapped word address carry no information.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW], req_addr[1:0]};

  assign accept = (state_q == IDLE) && req_valid;

  // Write acknowledges always report the addressed word; refills start at
  // word 0 unless critical-word-first is built in.
`ifdef REFILL_CWF_EN
  assign first_beat = waddr_q[BW-1:0];
`else
  assign first_beat = we_q ? waddr_q[BW-1:0] : '0;
`endif

  // Current beat address: line base of the captured address plus beat index,
  // so the burst wraps inside the line rather than into the next one.
  assign rd_waddr = (waddr_q & ~LINE_MASK) | WW'(beat_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    nbeat_d = nbeat_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = BURST;
          beat_d  = first_beat;
          nbeat_d = '0;
          // The write lands on the same edge that starts its acknowledge.
          mem_we  = we_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BURST: begin
        if (we_q || (nbeat_q == LAST_BEAT)) begin
          state_d = IDLE;
        end else begin
          beat_d  = beat_q + 1'b1;
          nbeat_d = nbeat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      nbeat_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      nbeat_q <= nbeat_d;
      if (accept) begin
        we_q    <= req_we;
        wdata_q <= req_wdata;
        waddr_q <= req_addr[AW-1:2];
      end
    end
  end

  // Backing store keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      bytes[{waddr_q, 2'b00}] <= wdata_q[31:24];
      bytes[{waddr_q, 2'b01}] <= wdata_q[23:16];
      bytes[{waddr_q, 2'b10}] <= wdata_q[15:8];
      bytes[{waddr_q, 2'b11}] <= wdata_q[7:0];
    end
  end

  // All outputs are decoded from registered state only.
  always_comb begin
    req_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    resp_valid = (state_q == BURST);
    resp_last  = 1'b0;
    resp_beat  = '0;
    resp_data  = '0;
    if (state_q == BURST) begin
      resp_last = we_q || (nbeat_q == LAST_BEAT);
      resp_beat = beat_q;
      if (!we_q) begin
        resp_data = {bytes[{rd_waddr, 2'b00}], bytes[{rd_waddr, 2'b01}],
                     bytes[{rd_waddr, 2'b10}], bytes[{rd_waddr, 2'b11}]};
      end
    end
  end

endmodule

// File: tb/tb_mem_refill_responder.sv
module tb_mem_refill_responder;

  localparam int unsigned LW  = 4;
  localparam int unsigned LAT = 5;
  localparam int unsigned MB  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_beat;
  logic        resp_last;
  logic        busy;

  mem_refill_responder #(
    .LINE_WORDS(LW),
    .LATENCY   (LAT),
    .MEM_BYTES (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_beat (resp_beat),
    .resp_last (resp_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  beat;
    logic        last;
  } beat_t;

  beat_t      sbq[$];
  logic [7:0] mdl [0:MB-1];
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] addr);
    logic [9:0] a;
    a = addr[9:0];
    return {mdl[a], mdl[a + 10'd1], mdl[a + 10'd2], mdl[a + 10'd3]};
  endfunction

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
    logic [9:0] a;
    beat_t      e;
    a = {addr[9:2], 2'b00};
    mdl[a]         = data[31:24];
    mdl[a + 10'd1] = data[23:16];
    mdl[a + 10'd2] = data[15:8];
    mdl[a + 10'd3] = data[7:0];
    e.data = 32'h0;
    e.beat = addr[3:2];
    e.last = 1'b1;
    sbq.push_back(e);
  endtask

  task automatic push_refill(input logic [31:0] addr);
    logic [1:0]  first;
    logic [1:0]  b;
    logic [31:0] base;
    beat_t       e;
    base = addr & (MB - 1) & ~32'hF;
`ifdef REFILL_CWF_EN
    first = addr[3:2];
`else
    first = 2'd0;
`endif
    for (int i = 0; i < LW; i++) begin
      b      = first + 2'(i);
      e.data = mword(base + {28'd0, b, 2'b00});
      e.beat = b;
      e.last = (i == LW - 1);
      sbq.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input bit hold);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(req_ready), 32'd0);
  endtask

  task automatic collect(input int n, input string tag);
    int    k;
    beat_t e;
    k = 0;
    while (resp_valid !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k), LAT);
    if (resp_valid !== 1'b1) return;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s_scoreboard: observed=beat expected=none", tag);
        return;
      end
      e = sbq.pop_front();
      chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_data"},  resp_data,       e.data);
      chk({tag, "_beat"},  32'(resp_beat),  32'(e.beat));
      chk({tag, "_last"},  32'(resp_last),  32'(e.last));
    end
    @(negedge clk);
    chk({tag, "_busy_end"},  32'(busy),       32'd0);
    chk({tag, "_ready_end"}, 32'(req_ready),  32'd1);
    chk({tag, "_valid_end"}, 32'(resp_valid), 32'd0);
  endtask

  logic [31:0] pre_a [11];
  logic [31:0] pre_d [11];

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < MB; i++) mdl[i] = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready),  32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data",  resp_data,       32'd0);
    chk("rst_beat",  32'(resp_beat),  32'd0);
    chk("rst_last",  32'(resp_last),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Preload the lines read later through ordinary write requests.
    pre_a = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h14, 32'h18, 32'h1C,
              32'h20, 32'h24, 32'h28, 32'h2C};
    pre_d = '{32'hF0783C1E, 32'h0F070300, 32'h0, 32'h0, 32'h11112222, 32'h33334444,
              32'h55556666, 32'hA5A50001, 32'h0, 32'hC3C3C3C3, 32'h0};
    for (int i = 0; i < 11; i++) begin
      push_write(pre_a[i], pre_d[i]);
      send(1'b1, pre_a[i], pre_d[i], 1'b0);
      collect(1, "preload_ack");
    end

    push_refill(32'h0);
    send(1'b0, 32'h0, 32'h0, 1'b0);
    collect(LW, "refill_0");

    push_refill(32'h4);
    send(1'b0, 32'h4, 32'h0, 1'b0);
    collect(LW, "refill_4");

    push_write(32'h10, 32'hDEADBEEF);
    send(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    collect(1, "write_10");
    push_refill(32'h10);
    send(1'b0, 32'h10, 32'h0, 1'b0);
    collect(LW, "refill_10");
    chk("mem_byte16", 32'(dut.bytes[16]), 32'hDE);

    // Second request held throughout the first one's wait and burst.
    push_refill(32'h0);
    send(1'b0, 32'h0, 32'h0, 1'b1);
    req_addr = 32'h4;
    push_refill(32'h4);
    collect(LW, "b2b_first");
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_busy_accept", 32'(busy), 32'd1);
    collect(LW, "b2b_second");

    // Reset during beat 1 of a refill.
    push_refill(32'h0);
    send(1'b0, 32'h0, 32'h0, 1'b0);
    k = 0;
    while (resp_valid !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("abort_latency", 32'(k), LAT);
    @(negedge clk);
    chk("abort_beat1", 32'(resp_beat), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_busy",  32'(busy),       32'd0);
    chk("abort_ready", 32'(req_ready),  32'd1);
    chk("abort_last",  32'(resp_last),  32'd0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_refill(32'h4);
    send(1'b0, 32'h4, 32'h0, 1'b0);
    collect(LW, "after_abort");

    // A write interrupted in its wait phase must not reach memory.
    send(1'b1, 32'h20, 32'h12345678, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("drop_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_refill(32'h20);
    send(1'b0, 32'h20, 32'h0, 1'b0);
    collect(LW, "dropped_write");

    // Address beyond MEM_BYTES wraps back onto the same line.
    push_refill(MB + 32'h4);
    send(1'b0, MB + 32'h4, 32'h0, 1'b0);
    collect(LW, "wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
